sb_corner_cfg_tile: RTL and testbench

Parametrised next-generation corner switch-box tile for the FPGA fabric. It routes chanx/chany tracks and inpad pins through configurable 4:1 muxes. The mux configuration is loaded over the ccff scan chain into a shadow register and committed atomically to the active register. A bit counter and FSM track chain length and flag complete or over-shifted loads, so partially shifted config never reaches routing.

---
 rtl/sb_cfg_pkg.sv | 26 ++
 rtl/sb_corner_cfg_tile_if.sv | 33 +++
 rtl/sb_route_mux4.sv | 24 ++
 rtl/sb_corner_cfg_tile.sv | 129 ++++++++++++
 tb/tb_sb_corner_cfg_tile.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the corner switch-box configuration tile:
// mux select encodings, configuration FSM states and chain-length helper.
package sb_cfg_pkg;

  localparam int SEL_BITS = 2;

  typedef enum logic [SEL_BITS-1:0] {
    SEL_STRAIGHT = 2'd0,
    SEL_DIAG     = 2'd1,
    SEL_PAD_TL   = 2'd2,
    SEL_PAD_RB   = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } cfg_state_e;

  // Two routed directions, one mux per track, SEL_BITS per mux.
  function automatic int cfg_bits_calc(input int chan_width);
    return 2 * chan_width * SEL_BITS;
  endfunction

endpackage

// File: rtl/sb_corner_cfg_tile_if.sv
// Bundle of the ccff scan-chain and routing signals of the corner tile.
// master = tile driver (fabric/testbench), slave = the tile itself.
interface sb_corner_cfg_tile_if #(
  parameter int CHAN_WIDTH = 30,
  parameter int NUM_PADS   = 4
);

  logic                  ccff_head;
  logic                  ccff_shift_en;
  logic                  ccff_commit;
  logic [CHAN_WIDTH-1:0] chanx_right_in;
  logic [CHAN_WIDTH-1:0] chany_top_in;
  logic [NUM_PADS-1:0]   top_left_pad_in;
  logic [NUM_PADS-1:0]   right_bottom_pad_in;
  logic                  ccff_tail;
  logic [CHAN_WIDTH-1:0] chanx_right_out;
  logic [CHAN_WIDTH-1:0] chany_top_out;
  logic                  cfg_done;
  logic                  cfg_overflow;

  modport master (
    output ccff_head, ccff_shift_en, ccff_commit,
    output chanx_right_in, chany_top_in, top_left_pad_in, right_bottom_pad_in,
    input  ccff_tail, chanx_right_out, chany_top_out, cfg_done, cfg_overflow
  );

  modport slave (
    input  ccff_head, ccff_shift_en, ccff_commit,
    input  chanx_right_in, chany_top_in, top_left_pad_in, right_bottom_pad_in,
    output ccff_tail, chanx_right_out, chany_top_out, cfg_done, cfg_overflow
  );

endinterface

// File: rtl/sb_route_mux4.sv
// Single 4:1 routing mux for one output track. i_data is ordered so that
// its index equals the select encoding from sb_cfg_pkg.
module sb_route_mux4
  import sb_cfg_pkg::*;
(
  input  logic [SEL_BITS-1:0] i_sel,
  input  logic [3:0]          i_data,
  output logic                o_out
);

  // Select one of straight track, diagonal track or one of the two pad sets.
  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    o_out = 1'b0;
    case (i_sel)
      SEL_STRAIGHT: o_out = i_data[0];
      SEL_DIAG:     o_out = i_data[1];
      SEL_PAD_TL:   o_out = i_data[2];
      SEL_PAD_RB:   o_out = i_data[3];
      default:      o_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/sb_corner_cfg_tile.sv
// Corner switch-box tile: ccff scan chain into a shadow register, atomic
// commit into the active register, and 2*CHAN_WIDTH combinational 4:1 muxes.
// Optional build macro SB_CFG_PARITY_EN appends an even-parity bit to the
// chain and rejects commits whose parity does not match.
module sb_corner_cfg_tile
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_WIDTH = 30,
  parameter int NUM_PADS   = 4
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  sb_corner_cfg_tile_if.slave  bus
);

  localparam int CFG_BITS = cfg_bits_calc(CHAN_WIDTH);
`ifdef SB_CFG_PARITY_EN
  localparam int CHAIN_BITS = CFG_BITS + 1;
`else
  localparam int CHAIN_BITS = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(CHAIN_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_CHAIN = CNT_W'(CHAIN_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CHAIN_BITS + 1);

  logic [CHAIN_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0]   r_active;
  logic [CNT_W-1:0]      r_bit_cnt;
  cfg_state_e            r_state;
  logic                  r_cfg_done;
  logic                  r_cfg_overflow;

  logic [CHAIN_BITS-1:0] w_shadow_post;
  logic [CFG_BITS-1:0]   w_cfg_post;
  logic                  w_parity_ok;
  logic [CNT_W-1:0]      w_cnt_post;
  cfg_state_e            w_state_post;
  logic                  w_commit_ok;
  logic                  w_enter_over;
  logic [CHAN_WIDTH-1:0] w_chanx_out;
  logic [CHAN_WIDTH-1:0] w_chany_out;

  // Post-shift view: commit in the same cycle observes the shifted state.
  always_comb begin
    w_shadow_post = r_shadow;
    w_cnt_post    = r_bit_cnt;
    w_state_post  = r_state;
    if (bus.ccff_shift_en) begin
      w_shadow_post = {r_shadow[CHAIN_BITS-2:0], bus.ccff_head};
      if (r_bit_cnt != CNT_MAX) w_cnt_post = r_bit_cnt + 1'b1;
      case (r_state)
        IDLE, SHIFT: w_state_post = (w_cnt_post == CNT_CHAIN) ? FULL : SHIFT;
        FULL, OVER:  w_state_post = OVER;
        default:     w_state_post = IDLE;
      endcase
    end
  end

  // Split the chain into config bits and (optionally) the trailing parity bit.
`ifdef SB_CFG_PARITY_EN
  assign w_cfg_post  = w_shadow_post[CHAIN_BITS-1:1];
  assign w_parity_ok = ~^w_shadow_post;
`else
  assign w_cfg_post  = w_shadow_post;
  assign w_parity_ok = 1'b1;
`endif

  assign w_commit_ok  = bus.ccff_commit && (w_state_post == FULL || w_state_post == OVER);
  assign w_enter_over = (r_state != OVER) && (w_state_post == OVER);

  // Shadow shift register; its MSB is the registered chain tail.
  always_ff @(posedge prog_clk) begin
    // NOTE: the shadow is a plain register (not RAM) and has a defined reset value,
    // so it is cleared like any other state; the tail is then 0 after reset.
    if (prog_reset) r_shadow <= '0;
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of block ordering.
    else            r_shadow <= w_shadow_post;
  end

  // Load-tracking FSM with bit counter, registered status flags and commit.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_active       <= '0;
      r_cfg_done     <= 1'b0;
      r_cfg_overflow <= 1'b0;
    end else if (w_commit_ok) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_cfg_done     <= 1'b0;
      r_cfg_overflow <= ~w_parity_ok;
      if (w_parity_ok) r_active <= w_cfg_post;
    end else begin
      r_state        <= w_state_post;
      r_bit_cnt      <= w_cnt_post;
      r_cfg_done     <= (w_state_post == FULL);
      r_cfg_overflow <= r_cfg_overflow | w_enter_over;
    end
  end

  // Routing muxes: chanx outputs use the first half of active, chany the second.
  for (genvar gi = 0; gi < CHAN_WIDTH; gi++) begin : g_route
    localparam int NXT = (gi + 1) % CHAN_WIDTH;
    localparam int PAD = gi % NUM_PADS;

    sb_route_mux4 u_chanx_mux (
      .i_sel  (r_active[2*gi +: SEL_BITS]),
      .i_data ({bus.right_bottom_pad_in[PAD], bus.top_left_pad_in[PAD],
                bus.chany_top_in[NXT], bus.chany_top_in[gi]}),
      .o_out  (w_chanx_out[gi])
    );

    sb_route_mux4 u_chany_mux (
      .i_sel  (r_active[2*(CHAN_WIDTH+gi) +: SEL_BITS]),
      .i_data ({bus.right_bottom_pad_in[PAD], bus.top_left_pad_in[PAD],
                bus.chanx_right_in[NXT], bus.chanx_right_in[gi]}),
      .o_out  (w_chany_out[gi])
    );
  end

  assign bus.chanx_right_out = w_chanx_out;
  assign bus.chany_top_out   = w_chany_out;
  assign bus.ccff_tail       = r_shadow[CHAIN_BITS-1];
  assign bus.cfg_done        = r_cfg_done;
  assign bus.cfg_overflow    = r_cfg_overflow;

endmodule

// File: tb/tb_sb_corner_cfg_tile.sv
// Testbench for sb_corner_cfg_tile (default build, parity disabled).
module tb_sb_corner_cfg_tile;

  localparam int CW  = 30;
  localparam int NP  = 4;
  localparam int CFG = 2 * CW * 2;

  typedef struct {
    logic [1:0]    sel_x;
    logic [1:0]    sel_y;
    logic [CW-1:0] chany;
    logic [CW-1:0] chanx;
    logic [NP-1:0] tl;
    logic [NP-1:0] rb;
    logic [CW-1:0] exp_x;
    logic [CW-1:0] exp_y;
  } vec_t;

  logic prog_clk = 1'b0;
  logic prog_reset;
  int   tests = 0;
  int   fails = 0;

  // Reference model state: shadow as a queue (front = MSB), count of bits
  // shifted since the last accepted commit/reset, and the committed config.
  bit             m_hist[$];
  int             m_count;
  logic [CFG-1:0] m_active;

  always #5 prog_clk = ~prog_clk;

  sb_corner_cfg_tile_if #(.CHAN_WIDTH(CW), .NUM_PADS(NP)) bus ();

  sb_corner_cfg_tile #(.CHAN_WIDTH(CW), .NUM_PADS(NP)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .bus        (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] route(input logic [CFG-1:0] act, input int base,
                                          input logic [CW-1:0] ch,
                                          input logic [NP-1:0] tl, input logic [NP-1:0] rb);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CW; i++) begin
      int s;
      s = int'(act[2*(base+i) +: 2]);
      if (s == 0)      r[i] = ch[i];
      else if (s == 1) r[i] = ch[(i+1) % CW];
      else if (s == 2) r[i] = tl[i % NP];
      else             r[i] = rb[i % NP];
    end
    return r;
  endfunction

  task automatic model_step(input logic h, input logic s, input logic c, input logic r);
    if (r) begin
      m_hist = {};
      repeat (CFG) m_hist.push_back(1'b0);
      m_count  = 0;
      m_active = '0;
    end else begin
      if (s) begin
        m_hist.push_back(h);
        void'(m_hist.pop_front());
        m_count++;
      end
      if (c && m_count >= CFG) begin
        for (int k = 0; k < CFG; k++) m_active[k] = m_hist[CFG-1-k];
        m_count = 0;
      end
    end
  endtask

  // One clock: drive controls, take the edge, advance the model, release controls.
  task automatic cyc(input logic h, input logic s, input logic c, input logic r);
    bus.ccff_head     = h;
    bus.ccff_shift_en = s;
    bus.ccff_commit   = c;
    prog_reset        = r;
    @(posedge prog_clk);
    #1;
    model_step(h, s, c, r);
    bus.ccff_shift_en = 1'b0;
    bus.ccff_commit   = 1'b0;
    prog_reset        = 1'b0;
  endtask

  task automatic rand_data();
    bus.chanx_right_in      = CW'($urandom);
    bus.chany_top_in        = CW'($urandom);
    bus.top_left_pad_in     = NP'($urandom);
    bus.right_bottom_pad_in = NP'($urandom);
  endtask

  task automatic check_model(input string tag);
    check({tag, " chanx_out"}, 64'(bus.chanx_right_out),
          64'(route(m_active, 0, bus.chany_top_in, bus.top_left_pad_in, bus.right_bottom_pad_in)));
    check({tag, " chany_out"}, 64'(bus.chany_top_out),
          64'(route(m_active, CW, bus.chanx_right_in, bus.top_left_pad_in, bus.right_bottom_pad_in)));
    check({tag, " tail"},     64'(bus.ccff_tail),    64'(m_hist[0]));
    check({tag, " done"},     64'(bus.cfg_done),     64'(m_count == CFG));
    check({tag, " overflow"}, 64'(bus.cfg_overflow), 64'(m_count > CFG));
  endtask

  // Shift a config giving every chanx mux sel_x and every chany mux sel_y.
  task automatic load_uniform(input logic [1:0] sx, input logic [1:0] sy, input bit commit_last);
    logic [CFG-1:0] cfg;
    for (int i = 0; i < CW; i++) begin
      cfg[2*i +: 2]      = sx;
      cfg[2*(CW+i) +: 2] = sy;
    end
    for (int k = CFG - 1; k >= 0; k--) begin
      rand_data();
      cyc(cfg[k], 1'b1, commit_last && (k == 0), 1'b0);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    bus.chany_top_in        = v.chany;
    bus.chanx_right_in      = v.chanx;
    bus.top_left_pad_in     = v.tl;
    bus.right_bottom_pad_in = v.rb;
    #1;
  endtask

  vec_t tbl[5];
  logic ov_bits[CFG+1];

  initial begin
    tbl[0] = '{2'd0, 2'd0, 30'h2AAAAAAA, 30'h15555555, 4'b0000, 4'b0000, 30'h2AAAAAAA, 30'h15555555};
    tbl[1] = '{2'd2, 2'd3, 30'h00000000, 30'h3FFFFFFF, 4'b0101, 4'b0011, 30'h15555555, 30'h33333333};
    tbl[2] = '{2'd3, 2'd2, 30'h3FFFFFFF, 30'h00000000, 4'b1000, 4'b1001, 30'h19999999, 30'h08888888};
    tbl[3] = '{2'd1, 2'd1, 30'h00000001, 30'h20000000, 4'b1111, 4'b0000, 30'h20000000, 30'h10000000};
    tbl[4] = '{2'd1, 2'd0, 30'h3FFFFFFE, 30'h12345678, 4'b0000, 4'b1111, 30'h1FFFFFFF, 30'h12345678};

    bus.ccff_head = 1'b0; bus.ccff_shift_en = 1'b0; bus.ccff_commit = 1'b0;
    bus.chanx_right_in = '0; bus.chany_top_in = 30'h2AAAAAAA;
    bus.top_left_pad_in = '0; bus.right_bottom_pad_in = '0;
    prog_reset = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset: straight-through routing, flags and tail low.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset chanx_out", 64'(bus.chanx_right_out), 64'(30'h2AAAAAAA));
    check("reset chany_out", 64'(bus.chany_top_out), 64'(30'h0));
    check("reset done", 64'(bus.cfg_done), 64'(0));
    check("reset tail", 64'(bus.ccff_tail), 64'(0));
    check("reset overflow", 64'(bus.cfg_overflow), 64'(0));

    // Table: full loads with uniform selects, then hand-computed routing.
    for (int t = 0; t < 5; t++) begin
      load_uniform(tbl[t].sel_x, tbl[t].sel_y, 1'b0);
      check($sformatf("tbl%0d done_before_commit", t), 64'(bus.cfg_done), 64'(1));
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("tbl%0d done_after_commit", t), 64'(bus.cfg_done), 64'(0));
      apply_vec(tbl[t]);
      check($sformatf("tbl%0d chanx_out", t), 64'(bus.chanx_right_out), 64'(tbl[t].exp_x));
      check($sformatf("tbl%0d chany_out", t), 64'(bus.chany_top_out), 64'(tbl[t].exp_y));
    end

    // Early commit after 119 bits is ignored; the 120th bit raises done.
    for (int k = 0; k < CFG - 1; k++) cyc(1'($urandom), 1'b1, 1'b0, 1'b0);
    rand_data();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_model("early");
    check("early done", 64'(bus.cfg_done), 64'(0));
    check("early chanx_unchanged", 64'(bus.chanx_right_out),
          64'(route(m_active, 0, bus.chany_top_in, bus.top_left_pad_in, bus.right_bottom_pad_in)));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("early done_at_120", 64'(bus.cfg_done), 64'(1));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Overshift by one bit, then commit captures the last 120 bits.
    for (int k = 0; k <= CFG; k++) begin
      ov_bits[k] = 1'($urandom);
      cyc(ov_bits[k], 1'b1, 1'b0, 1'b0);
    end
    check("over overflow", 64'(bus.cfg_overflow), 64'(1));
    check("over done", 64'(bus.cfg_done), 64'(0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("over overflow_cleared", 64'(bus.cfg_overflow), 64'(0));
    rand_data();
    #1;
    check_model("over");

    // Readback: the retained shadow streams out on the tail in shift order.
    for (int j = 0; j < CFG; j++) begin
      check($sformatf("readback bit%0d", j), 64'(bus.ccff_tail), 64'(ov_bits[j+1]));
      cyc(1'($urandom), 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Commit together with the 120th shift is accepted.
    load_uniform(tbl[2].sel_x, tbl[2].sel_y, 1'b1);
    check("simul done", 64'(bus.cfg_done), 64'(0));
    apply_vec(tbl[2]);
    check("simul chanx_out", 64'(bus.chanx_right_out), 64'(tbl[2].exp_x));
    check("simul chany_out", 64'(bus.chany_top_out), 64'(tbl[2].exp_y));

    // Reset in the middle of a shift wins over the shift.
    for (int k = 0; k < 50; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("midreset tail", 64'(bus.ccff_tail), 64'(0));
    check("midreset done", 64'(bus.cfg_done), 64'(0));
    check_model("midreset");

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic s, c, r;
      s = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 499) == 0);
      rand_data();
      cyc(1'($urandom), s, c, r);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
